// File: rtl/key_pkg.sv
// Purpose: shared constants for the push-button conditioner (timing defaults, FSM states, key codes).
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package key_pkg;

    // Default timing at 50 MHz: 10 ms debounce, 500 ms repeat delay, 100 ms repeat period.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned REPEAT_DELAY_DEF    = 25000000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 5000000;
    localparam int unsigned CNT_W_DEF           = 25;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } key_state_e;

    // Move codes seen by the game controller: {right, left}.
    localparam logic [1:0] KEY_NONE  = 2'b00;
    localparam logic [1:0] KEY_LEFT  = 2'b01;
    localparam logic [1:0] KEY_RIGHT = 2'b10;

endpackage

// File: rtl/key_debounce.sv
// Purpose: one button channel - 2-flop synchroniser, debounce counter, press FSM, optional repeat counter.
// Latency: registered pulse DEBOUNCE_CYCLES+2 edges after the first edge sampling a clean rising btn.
// Backpressure: none; pulses are fire-and-forget single-cycle strobes.
// Ports: clk, rst_n (sync, active-low), btn (raw async level), pulse (1-cycle move strobe), stable (debounced level).
// Build option: KEY_AUTOREPEAT_EN adds the REPEAT state and the rcnt repeat counter.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse,
    output logic stable
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    key_state_e       state_q, state_d;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
`else
    // Repeat timing only matters when auto-repeat is built in.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    // Synchroniser and debounce: any sample equal to the current stable level restarts the count.
    always_comb begin
        sync1_d  = btn;
        sync2_d  = sync1_q;
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == DB_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Press FSM. Release is tested first so it wins over a repeat falling in the same cycle.
    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_d  = rcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (stable_q) begin
                    state_d = ST_HELD;
                    pulse_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rcnt_d  = '0;
`endif
                end
            end
            ST_HELD: begin
                if (!stable_q) begin
                    state_d = ST_IDLE;
`ifdef KEY_AUTOREPEAT_EN
                    rcnt_d  = '0;
                end else if (rcnt_q == RD_LAST) begin
                    state_d = ST_REPEAT;
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d  = rcnt_q + 1'b1;
`endif
                end
            end
`ifdef KEY_AUTOREPEAT_EN
            ST_REPEAT: begin
                if (!stable_q) begin
                    state_d = ST_IDLE;
                    rcnt_d  = '0;
                end else if (rcnt_q == RP_LAST) begin
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d  = rcnt_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_q   <= '0;
`endif
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_q   <= rcnt_d;
`endif
        end
    end

    assign pulse  = pulse_q;
    assign stable = stable_q;

endmodule

// File: rtl/key_conditioner.sv
// Purpose: turns BTNL/BTNR into one-shot {right,left} move pulses plus debounced held levels.
// Latency: key pulse DEBOUNCE_CYCLES+3 edges after the first edge sampling a clean press.
// Backpressure: none; simultaneous left+right requests are dropped rather than queued.
// Ports: clk, rst_n (sync, active-low), btn_l/btn_r (raw async), key[1:0] (registered pulses), held[1:0] (registered levels).
// Build option: KEY_AUTOREPEAT_EN enables auto-repeat pulses while a button is held.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic [1:0] key,
    output logic [1:0] held
);

    logic       pulse_l, pulse_r;
    logic       stable_l, stable_r;
    logic [1:0] key_q, key_d;
    logic [1:0] held_q, held_d;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .CNT_W           (CNT_W)
    ) u_left (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn_l),
        .pulse  (pulse_l),
        .stable (stable_l)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD),
        .CNT_W           (CNT_W)
    ) u_right (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn_r),
        .pulse  (pulse_r),
        .stable (stable_r)
    );

    // Both directions in one cycle is ambiguous for the game, so neither move is issued.
    always_comb begin
        key_d  = {pulse_r, pulse_l};
        if (pulse_r && pulse_l) begin
            key_d = KEY_NONE;
        end
        held_d = {stable_r, stable_l};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q  <= KEY_NONE;
            held_q <= 2'b00;
        end else begin
            key_q  <= key_d;
            held_q <= held_d;
        end
    end

    assign key  = key_q;
    assign held = held_q;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_l = 1'b0;
    logic       btn_r = 1'b0;
    logic [1:0] key;
    logic [1:0] held;

    key_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (25)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_l (btn_l),
        .btn_r (btn_r),
        .key   (key),
        .held  (held)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] k;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_pulse = 0;
    logic [1:0] held_exp = 2'b00;

    // Reference model state, indexed 0 = left, 1 = right.
    bit          s1[2], s2[2], stb[2], pm[2], pn[2];
    int          rise[2];
    logic [63:0] hist[2];

    // Pulse schedule relative to the edge where the debounced level rose:
    // press one edge later, then (auto-repeat) RD after it, then every RP.
    function automatic bit pulse_due(int k);
        int d;
        d = k - 1;
        if (d == 0) return 1'b1;
`ifdef KEY_AUTOREPEAT_EN
        if (d >= RD && ((d - RD) % RP) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Model: advances at every rising edge from the inputs applied before it.
    initial begin
        logic [1:0]  kv;
        logic [63:0] mask;
        logic [63:0] win;
        bit          seen;
        mask = (64'd1 << D) - 64'd1;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                for (int ch = 0; ch < 2; ch++) begin
                    s1[ch] = 0; s2[ch] = 0; stb[ch] = 0; pm[ch] = 0;
                    rise[ch] = 0; hist[ch] = '0;
                end
                held_exp = 2'b00;
            end else begin
                kv = {pm[1], pm[0]};
                if (kv == 2'b11) kv = 2'b00;
                if (kv != 2'b00) exp_q.push_back('{cyc, kv});
                held_exp = {stb[1], stb[0]};
                for (int ch = 0; ch < 2; ch++)
                    pn[ch] = stb[ch] && pulse_due(cyc - rise[ch]);
                for (int ch = 0; ch < 2; ch++) begin
                    // The debouncer sees the button as sampled two edges earlier;
                    // the level is accepted once the last D views all disagree with it.
                    seen     = s2[ch];
                    hist[ch] = {hist[ch][62:0], seen};
                    win      = hist[ch] & mask;
                    if ((stb[ch] && win == 64'd0) || (!stb[ch] && win == mask)) begin
                        stb[ch] = !stb[ch];
                        if (stb[ch]) rise[ch] = cyc;
                    end
                    s2[ch] = s1[ch];
                    s1[ch] = (ch == 0) ? btn_l : btn_r;
                end
                pm = pn;
            end
        end
    end

    // Monitor: compares on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                n_chk++;
                if (held !== held_exp) begin
                    n_fail++;
                    $display("FAIL held cyc=%0d got=%b want=%b", cyc, held, held_exp);
                end
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    n_chk++; n_fail++;
                    $display("FAIL key_missing cyc=%0d got=none want=%b@%0d", cyc, e.k, e.cyc);
                end
                if (key !== 2'b00) begin
                    n_chk++;
                    n_pulse++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL key_unexpected cyc=%0d got=%b want=00", cyc, key);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.k !== key) begin
                            n_fail++;
                            $display("FAIL key_pulse cyc=%0d got=%b want=%b@%0d", cyc, key, e.k, e.cyc);
                        end
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    n_chk++; n_fail++;
                    $display("FAIL key_missing cyc=%0d got=00 want=%b", cyc, e.k);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus
    initial begin
        int r;
        cycles(3);
        // Reset with left already held, then release reset.
        btn_l = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(20);
        btn_l = 1'b0;
        cycles(30);
        // Bounce on right: high periods shorter than the debounce window.
        for (int i = 0; i < 7; i++) begin
            btn_r = 1'b1; cycles(3);
            btn_r = 1'b0; cycles(3);
        end
        btn_r = 1'b1; cycles(20);
        btn_r = 1'b0; cycles(30);
        // Hold and release left.
        btn_l = 1'b1; cycles(30);
        btn_l = 1'b0; cycles(30);
        // Simultaneous press.
        btn_l = 1'b1; btn_r = 1'b1; cycles(30);
        btn_l = 1'b0; btn_r = 1'b0; cycles(30);
        // Staggered press, right 4 cycles after left.
        btn_l = 1'b1; cycles(4);
        btn_r = 1'b1; cycles(30);
        btn_l = 1'b0; btn_r = 1'b0; cycles(30);
        // Long hold (auto-repeat when built in).
        btn_l = 1'b1; cycles(60);
        btn_l = 1'b0; cycles(30);
        // Long right hold while left taps, plus a mid-hold reset.
        btn_r = 1'b1; cycles(15);
        btn_l = 1'b1; cycles(12);
        btn_l = 1'b0; cycles(30);
        rst_n = 1'b0; cycles(2);
        rst_n = 1'b1; cycles(30);
        btn_r = 1'b0; cycles(30);
        // Random glitches, holds and occasional resets.
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 11));
            if (r == 0) begin
                rst_n = 1'b0;
                cycles(int'($urandom_range(1, 3)));
                rst_n = 1'b1;
            end else begin
                btn_l = 1'($urandom_range(0, 1));
                btn_r = 1'($urandom_range(0, 1));
                cycles(int'($urandom_range(1, 40)));
            end
        end
        btn_l = 1'b0; btn_r = 1'b0;
        cycles(40);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        n_chk++;
        if (n_pulse < 5) begin
            n_fail++;
            $display("FAIL pulse_count got=%0d want>=5", n_pulse);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
